// File: rtl/vco_freq_meter.sv
// Counts synchronised VCO rising edges over a gate of GATE_BASE << gate_sel clk cycles and steers up/dn.
// Optional: define VCO_FREQ_METER_OVF_EN for the sticky saturation flag and forced dn on a saturated count.
module vco_freq_meter #(
  parameter int COUNT_W   = 16,
  parameter int TOL_W     = 8,
  parameter int GATE_BASE = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               vco_in,
  input  logic               start,
  input  logic               cont,
  input  logic [1:0]         gate_sel,
  input  logic [COUNT_W-1:0] target,
  input  logic [TOL_W-1:0]   tol,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  input  logic               count_ready,
  output logic               up,
  output logic               dn,
  output logic               ovf
);

  // GW bits hold L-1 for every gate_sel; base << 3 may wrap to 0, and the -1 still lands on L-1.
  localparam int GW = $clog2(GATE_BASE) + 3;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, GATE, HOLD} state_e;

  state_e             state_q;
  logic               sync1_q, sync2_q, hist_q;
  logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [GW-1:0]      gate_cnt_q, gate_len_m1;
  logic [COUNT_W-1:0] count_q;
  logic               valid_q, up_q, dn_q;
  logic               edge_pulse;
  logic [COUNT_W:0]   tgt_x, tol_x, lo, hi, cnt_x;
  logic               up_d, dn_d;

  assign edge_pulse  = sync2_q & ~hist_q;
  assign edge_cnt_d  = (edge_pulse && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
  assign gate_len_m1 = (GW'(GATE_BASE) << gate_sel) - 1'b1;

  // Band compare is one bit wider so target+tol never wraps and target-tol can be clamped at 0.
  assign tgt_x = {1'b0, target};
  assign tol_x = (COUNT_W+1)'(tol);
  assign lo    = (tgt_x > tol_x) ? tgt_x - tol_x : '0;
  assign hi    = tgt_x + tol_x;
  assign cnt_x = {1'b0, edge_cnt_d};
  assign up_d  = cnt_x < lo;
`ifdef VCO_FREQ_METER_OVF_EN
  assign dn_d  = (cnt_x > hi) || (edge_cnt_d == CNT_MAX);
`else
  assign dn_d  = cnt_x > hi;
`endif

  assign count_out   = count_q;
  assign count_valid = valid_q;
  assign up          = up_q;
  assign dn          = dn_q;

`ifdef VCO_FREQ_METER_OVF_EN
  logic ovf_q;
  logic sat_hit;
  assign sat_hit = edge_pulse && (edge_cnt_d == CNT_MAX);
  assign ovf     = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ena && (state_q == GATE) && sat_hit) begin
      ovf_q <= 1'b1;
    end else if (ena && (state_q == HOLD) && count_ready && start) begin
      ovf_q <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
      edge_cnt_q <= '0;
      gate_cnt_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
    end else begin
      sync1_q <= vco_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (!ena) begin
        state_q    <= IDLE;
        edge_cnt_q <= '0;
        valid_q    <= 1'b0;
        up_q       <= 1'b0;
        dn_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            edge_cnt_q <= '0;
            if (start || cont) begin
              state_q    <= GATE;
              gate_cnt_q <= gate_len_m1;
            end
          end
          GATE: begin
            edge_cnt_q <= edge_cnt_d;
            if (gate_cnt_q == '0) begin
              count_q <= edge_cnt_d;
              up_q    <= up_d;
              dn_q    <= dn_d;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              gate_cnt_q <= gate_cnt_q - 1'b1;
            end
          end
          HOLD: begin
            if (count_ready) begin
              valid_q    <= 1'b0;
              edge_cnt_q <= '0;
              if (cont) begin
                state_q    <= GATE;
                gate_cnt_q <= gate_len_m1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vco_freq_meter.sv
// Self-checking bench for vco_freq_meter: square-wave VCO stimulus, expected counts from recorded rise times.
module tb_vco_freq_meter;

  localparam int COUNT_W   = 11;
  localparam int TOL_W     = 8;
  localparam int GATE_BASE = 1024;
  localparam int MX        = (1 << COUNT_W) - 1;
`ifdef VCO_FREQ_METER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n, ena, vco_in, start, cont, count_ready;
  logic [1:0]         gate_sel;
  logic [COUNT_W-1:0] target;
  logic [TOL_W-1:0]   tol;
  logic [COUNT_W-1:0] count_out;
  logic               count_valid, up, dn, ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int half_ns = 40;
  bit exp_ovf = 1'b0;
  int rises[$];

  vco_freq_meter #(.COUNT_W(COUNT_W), .TOL_W(TOL_W), .GATE_BASE(GATE_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vco_in(vco_in), .start(start), .cont(cont),
    .gate_sel(gate_sel), .target(target), .tol(tol), .count_out(count_out),
    .count_valid(count_valid), .count_ready(count_ready), .up(up), .dn(dn), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toggles sit at 2 mod 5 ns, never on a clk edge; each rise is stamped with the clk interval it falls in.
  initial begin
    vco_in = 1'b0;
    #2;
    forever begin
      #(half_ns);
      vco_in = ~vco_in;
      if (vco_in) rises.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A rise in interval r is counted when r+2 lies inside the gate intervals c+1..c+L.
  function automatic int model_count(input int c, input int len);
    int n = 0;
    foreach (rises[i]) if (rises[i] >= c - 1 && rises[i] <= c + len - 2) n++;
    return n;
  endfunction

  function automatic int clamp(input int n);
    return (n > MX) ? MX : n;
  endfunction

  task automatic check_result(input string tag, input int c, input int len,
                              input int tgt, input int tl, output int exp_cnt);
    int n, lo;
    n = model_count(c, len);
    exp_cnt = clamp(n);
    lo = (tgt > tl) ? tgt - tl : 0;
    if (OVF_EN && n >= MX) exp_ovf = 1'b1;
    check({tag, "_valid"}, count_valid, 1);
    check({tag, "_count"}, count_out, exp_cnt);
    check({tag, "_up"}, up, exp_cnt < lo);
    check({tag, "_dn"}, dn, (exp_cnt > tgt + tl) || (OVF_EN && n >= MX));
    check({tag, "_ovf"}, ovf, exp_ovf);
    $display("%s: window %0d cycles, count %0d, up %0b dn %0b ovf %0b", tag, len, count_out, up, dn, ovf);
  endtask

  task automatic run_window(input int gsel, input int tgt, input int tl, input bit poke,
                            input string tag, output int exp_cnt);
    int c, len;
    len = GATE_BASE << gsel;
    gate_sel = 2'(gsel);
    target = COUNT_W'(tgt);
    tol = TOL_W'(tl);
    @(negedge clk);
    while (rises.size() > 0 && rises[0] < cyc - 4) void'(rises.pop_front());
    c = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + len) begin
      @(negedge clk);
      start = poke && (cyc == c + 100);
    end
    start = 1'b0;
    check({tag, "_valid_early"}, count_valid, 0);
    @(negedge clk);
    check_result(tag, c, len, tgt, tl, exp_cnt);
  endtask

  task automatic handshake(input bit with_start, input string tag);
    @(negedge clk);
    count_ready = 1'b1;
    start = with_start;
    @(negedge clk);
    count_ready = 1'b0;
    start = 1'b0;
    if (with_start) exp_ovf = 1'b0;
    check({tag, "_ack_valid"}, count_valid, 0);
    check({tag, "_ack_ovf"}, ovf, exp_ovf);
    $display("%s: handshake (start=%0b), valid %0b ovf %0b", tag, with_start, count_valid, ovf);
  endtask

  initial begin
    int cnt, c, h, len, tgt, tl, per;
    bit stable;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; cont = 1'b0; count_ready = 1'b0;
    gate_sel = 2'd0; target = '0; tol = '0;
    repeat (4) @(negedge clk);
    check("rst_count", count_out, 0);
    check("rst_valid", count_valid, 0);
    check("rst_up", up, 0);
    check("rst_dn", dn, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (4) @(negedge clk);

    half_ns = 40;
    run_window(0, 128, 2, 1'b0, "basic_p8", cnt);
    handshake(1'b0, "basic_p8");
    half_ns = 50;
    run_window(0, 128, 2, 1'b0, "slow_p10", cnt);
    handshake(1'b0, "slow_p10");
    half_ns = 30;
    run_window(0, 128, 2, 1'b1, "fast_p6", cnt);
    handshake(1'b0, "fast_p6");

    for (int i = 0; i < 4; i++) begin
      per = $urandom_range(3, 12);
      half_ns = 5 * per;
      tgt = $urandom_range(60, 400);
      tl = $urandom_range(0, 20);
      run_window($urandom_range(0, 1), tgt, tl, $urandom_range(0, 1), $sformatf("rand%0d_p%0d", i, per), cnt);
      handshake(1'b0, $sformatf("rand%0d", i));
    end

    // Continuous mode held off by backpressure, then released into a fresh window.
    half_ns = 35;
    len = GATE_BASE;
    gate_sel = 2'd0; target = 11'd146; tol = 8'd3;
    @(negedge clk);
    c = cyc;
    cont = 1'b1;
    while (cyc < c + len) @(negedge clk);
    check("bp_valid_early", count_valid, 0);
    @(negedge clk);
    check_result("bp_first", c, len, 146, 3, cnt);
    stable = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      if (count_valid !== 1'b1 || count_out !== COUNT_W'(cnt)) stable = 1'b0;
    end
    check("bp_hold_stable", stable, 1);
    half_ns = 45;
    count_ready = 1'b1;
    h = cyc;
    @(negedge clk);
    count_ready = 1'b0;
    check("bp_release_valid", count_valid, 0);
    while (cyc < h + len) @(negedge clk);
    check("bp_second_early", count_valid, 0);
    @(negedge clk);
    check_result("bp_second", h, len, 146, 3, cnt);
    cont = 1'b0;
    handshake(1'b0, "bp_second");

    // Abort in HOLD with up set, then abort mid-gate.
    half_ns = 50;
    run_window(0, 128, 2, 1'b0, "abort_hold", cnt);
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("abort_hold_valid", count_valid, 0);
    check("abort_hold_up", up, 0);
    check("abort_hold_count", count_out, cnt);
    ena = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    repeat (GATE_BASE + 20) @(negedge clk);
    check("abort_gate_valid", count_valid, 0);
    check("abort_gate_count", count_out, cnt);
    $display("abort: valid %0b count %0d after mid-gate abort", count_valid, count_out);

    // Saturation over the longest window, then sticky-flag behaviour.
    half_ns = 15;
    run_window(3, 2000, 100, 1'b0, "sat_p3", cnt);
    handshake(1'b0, "sat_p3");
    half_ns = 40;
    run_window(0, 128, 2, 1'b0, "post_sat", cnt);
    handshake(1'b1, "post_sat");

    // Asynchronous reset in the middle of a window.
    gate_sel = 2'd0;
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 500) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_count", count_out, 0);
    check("mid_rst_valid", count_valid, 0);
    check("mid_rst_up", up, 0);
    check("mid_rst_dn", dn, 0);
    check("mid_rst_ovf", ovf, 0);
    exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (GATE_BASE + 20) @(negedge clk);
    check("post_rst_idle_valid", count_valid, 0);
    check("post_rst_idle_count", count_out, 0);
    $display("reset: valid %0b count %0d after release", count_valid, count_out);
    run_window(0, 128, 2, 1'b0, "recover", cnt);
    handshake(1'b0, "recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
